mem_arbiter: RTL and testbench

Two-port arbiter that shares the single memory_bus (ROM, RAM, peripherals) between the CPU core (port 0) and a DMA/program-loader engine (port 1). It serialises requests, drives the bus enable/write strobes with correct one-access timing, and returns read data with a one-cycle ack pulse. It sits between the requesters and memory_bus and owns every mem_* signal.

---
 rtl/mem_arbiter_pkg.sv | 19 +
 rtl/mem_arbiter_select.sv | 25 ++
 rtl/mem_arbiter.sv | 132 +++++++++++++
 tb/tb_mem_arbiter.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the two-port memory bus arbiter.
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCESS  = 2'd1,
        RELEASE = 2'd2
    } state_t;

    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_DMA = 1'b1;

    // A write-mask bit at this value means the byte lane is written.
    localparam logic MASK_WRITE_LANE = 1'b0;

    // Wide enough for the largest supported read latency.
    typedef logic [1:0] cnt_t;

endpackage

// File: rtl/mem_arbiter_select.sv
// Combinational winner pick between the CPU and DMA request lines.
module arb_select
    import mem_arbiter_pkg::*;
#(
    parameter bit FIXED_PRIORITY = 1'b0
) (
    input  logic req_0,
    input  logic req_1,
    input  logic last_grant,
    output logic valid,
    output logic winner
);

    // NOTE: every output gets a default before any branch so no latch is inferred.
    always_comb begin
        valid  = req_0 | req_1;
        winner = PORT_CPU;
        if (req_0 && req_1) begin
            winner = FIXED_PRIORITY ? PORT_CPU : ~last_grant;
        end else if (req_1) begin
            winner = PORT_DMA;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares memory_bus between the CPU (port 0) and DMA (port 1): single-cycle
// strobes, LATENCY-aligned read capture and a one-cycle ack pulse.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int LATENCY        = 1,
    parameter int FIXED_PRIORITY = 0,
    parameter int ADDR_W         = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req_0,
    input  logic              req_1,
    input  logic [ADDR_W-1:0] addr_0,
    input  logic [ADDR_W-1:0] addr_1,
    input  logic [31:0]       wdata_0,
    input  logic [31:0]       wdata_1,
    input  logic [3:0]        wmask_0,
    input  logic [3:0]        wmask_1,
    input  logic              we_0,
    input  logic              we_1,
    output logic              ack_0,
    output logic              ack_1,
    output logic [31:0]       rdata,
    output logic              busy,
    output logic              grant_id,
    output logic [ADDR_W-1:0] mem_address,
    output logic [31:0]       mem_write,
    output logic [3:0]        mem_write_mask,
    output logic              mem_bus_enable,
    output logic              mem_write_enable,
    input  logic [31:0]       mem_read
);

    state_t state_q, state_d;
    cnt_t   cnt_q;
    logic   last_grant;
    logic   we_q;
    logic   sel_valid;
    logic   winner;
    logic   grant;
    logic   finish;

    arb_select #(
        .FIXED_PRIORITY(FIXED_PRIORITY != 0)
    ) u_select (
        .req_0     (req_0),
        .req_1     (req_1),
        .last_grant(last_grant),
        .valid     (sel_valid),
        .winner    (winner)
    );

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        grant   = 1'b0;
        finish  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (sel_valid) begin
                    grant   = 1'b1;
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                // cnt reaches zero on the edge where mem_read is valid.
                if (cnt_q == '0) begin
                    finish  = 1'b1;
                    state_d = RELEASE;
                end
            end
            RELEASE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: datapath registers are reset too, since every output must read 0 out of reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mem_address      <= '0;
            mem_write        <= '0;
            mem_write_mask   <= '0;
            mem_bus_enable   <= 1'b0;
            mem_write_enable <= 1'b0;
            we_q             <= 1'b0;
            grant_id         <= PORT_CPU;
            last_grant       <= PORT_DMA;
            busy             <= 1'b0;
            cnt_q            <= '0;
            ack_0            <= 1'b0;
            ack_1            <= 1'b0;
            rdata            <= '0;
        end else begin
            // Strobes follow the grant for exactly one cycle.
            mem_bus_enable   <= grant;
            mem_write_enable <= grant & (winner ? we_1 : we_0);
            ack_0            <= finish & (grant_id == PORT_CPU);
            ack_1            <= finish & (grant_id == PORT_DMA);

            if (grant) begin
                mem_address    <= winner ? addr_1  : addr_0;
                mem_write      <= winner ? wdata_1 : wdata_0;
                mem_write_mask <= winner ? wmask_1 : wmask_0;
                we_q           <= winner ? we_1    : we_0;
                grant_id       <= winner;
                last_grant     <= winner;
                busy           <= 1'b1;
                cnt_q          <= cnt_t'(LATENCY);
            end else if (state_q == ACCESS && cnt_q != '0) begin
                cnt_q <= cnt_q - 1'b1;
            end

            if (finish && !we_q) begin
                rdata <= mem_read;
            end

            if (state_q == RELEASE) begin
                busy <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: three instances (RR/LAT1, FIXED/LAT1, RR/LAT3)
// each backed by a small memory_bus model.
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    localparam int N = 3;

    typedef struct {
        int          dut;
        logic        port;
        logic [15:0] addr;
        logic        we;
        logic [31:0] wdata;
        logic [3:0]  wmask;
        logic [31:0] rdata;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        req_0 [N], req_1 [N], we_0 [N], we_1 [N];
    logic        ack_0 [N], ack_1 [N], busy [N], grant_id [N];
    logic        mem_bus_enable [N], mem_write_enable [N];
    logic [15:0] addr_0 [N], addr_1 [N], mem_address [N];
    logic [31:0] wdata_0 [N], wdata_1 [N], rdata [N], mem_write [N], mem_read [N];
    logic [3:0]  wmask_0 [N], wmask_1 [N], mem_write_mask [N];

    exp_t        exp_q [$];
    exp_t        mon_e;
    logic [31:0] last_rd [N];
    logic        prev_be [N], prev_ack [N];
    int          strobe_cyc [N];
    int          cyc = 0;
    int          checks = 0;
    int          failures = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int lat_of(int g);
        return (g == 2) ? 3 : 1;
    endfunction

    function automatic logic [31:0] init_word(logic [15:0] a);
        if (a[15:2] == 14'h1000) return 32'hDEAD_BEEF;
        if (a[15:2] == 14'h2000) return 32'h0000_0000;
        return {a, ~a};
    endfunction

    function automatic logic [31:0] merge(logic [31:0] old, logic [31:0] wd, logic [3:0] m);
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++) begin
            if (m[i] == MASK_WRITE_LANE) r[8*i +: 8] = wd[8*i +: 8];
        end
        return r;
    endfunction

    for (genvar g = 0; g < N; g++) begin : g_dut
        localparam int LAT = (g == 2) ? 3 : 1;
        localparam int FP  = (g == 1) ? 1 : 0;
        logic [31:0]    mem [16384];
        logic [16383:0] vld;
        logic [31:0]    p1, p2, p3;
        logic [13:0]    idx;
        assign idx = mem_address[g][15:2];

        mem_arbiter #(.LATENCY(LAT), .FIXED_PRIORITY(FP), .ADDR_W(16)) u_dut (
            .clk(clk), .reset_n(reset_n),
            .req_0(req_0[g]), .req_1(req_1[g]),
            .addr_0(addr_0[g]), .addr_1(addr_1[g]),
            .wdata_0(wdata_0[g]), .wdata_1(wdata_1[g]),
            .wmask_0(wmask_0[g]), .wmask_1(wmask_1[g]),
            .we_0(we_0[g]), .we_1(we_1[g]),
            .ack_0(ack_0[g]), .ack_1(ack_1[g]),
            .rdata(rdata[g]), .busy(busy[g]), .grant_id(grant_id[g]),
            .mem_address(mem_address[g]), .mem_write(mem_write[g]),
            .mem_write_mask(mem_write_mask[g]), .mem_bus_enable(mem_bus_enable[g]),
            .mem_write_enable(mem_write_enable[g]), .mem_read(mem_read[g])
        );

        // memory_bus model: samples the strobe, data_out valid LAT edges later
        always @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                vld <= '0;
                p1  <= '0;
                p2  <= '0;
                p3  <= '0;
            end else begin
                if (mem_bus_enable[g]) begin
                    if (mem_write_enable[g]) begin
                        mem[idx] <= merge(vld[idx] ? mem[idx] : init_word(mem_address[g]),
                                          mem_write[g], mem_write_mask[g]);
                        vld[idx] <= 1'b1;
                    end else begin
                        p1 <= vld[idx] ? mem[idx] : init_word(mem_address[g]);
                    end
                end
                p2 <= p1;
                p3 <= p2;
            end
        end
        assign mem_read[g] = (LAT == 1) ? p1 : (LAT == 2) ? p2 : p3;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int owner();
        return (exp_q.size() > 0) ? exp_q[0].dut : -1;
    endfunction

    function automatic void push(int g, logic port, logic [15:0] addr, logic we,
                                 logic [31:0] wdata, logic [3:0] wmask, logic [31:0] rd);
        exp_t e;
        e.dut   = g;
        e.port  = port;
        e.addr  = addr;
        e.we    = we;
        e.wdata = wdata;
        e.wmask = wmask;
        e.rdata = we ? last_rd[g] : rd;
        if (!we) last_rd[g] = rd;
        exp_q.push_back(e);
    endfunction

    task automatic set_port(input int g, input logic p, input logic [15:0] a, input logic we,
                            input logic [31:0] wd, input logic [3:0] wm);
        if (p == PORT_CPU) begin
            addr_0[g] = a; we_0[g] = we; wdata_0[g] = wd; wmask_0[g] = wm;
        end else begin
            addr_1[g] = a; we_1[g] = we; wdata_1[g] = wd; wmask_1[g] = wm;
        end
    endtask

    // Hold the requests until n acks arrive; optionally drop req_0 at ack drop0_at
    // and corrupt the requester inputs once the transaction is under way.
    task automatic hold_run(input int g, input logic r0, input logic r1, input int n,
                            input int drop0_at, input bit scramble);
        int seen = 0;
        int waited = 0;
        bit scrambled = 1'b0;
        @(negedge clk);
        req_0[g] = r0;
        req_1[g] = r1;
        while (seen < n && waited < 40 * n) begin
            @(negedge clk);
            waited++;
            if (scramble && !scrambled && mem_bus_enable[g]) begin
                addr_0[g] = 16'h1234; addr_1[g] = 16'h5678;
                we_0[g] = ~we_0[g];   we_1[g] = ~we_1[g];
                scrambled = 1'b1;
            end
            if (ack_0[g] || ack_1[g]) begin
                seen++;
                if (seen == drop0_at) req_0[g] = 1'b0;
            end
        end
        req_0[g] = 1'b0;
        req_1[g] = 1'b0;
        check("acks_seen", seen, n);
    endtask

    always @(negedge clk) begin
        for (int g = 0; g < N; g++) begin
            if (reset_n) begin
                if (mem_bus_enable[g]) begin
                    check("strobe_single", prev_be[g], 1'b0);
                    check("strobe_owner", owner(), g);
                    if (owner() == g) begin
                        check("strobe_addr", mem_address[g], exp_q[0].addr);
                        check("strobe_we", mem_write_enable[g], exp_q[0].we);
                        if (exp_q[0].we) begin
                            check("strobe_wdata", mem_write[g], exp_q[0].wdata);
                            check("strobe_wmask", mem_write_mask[g], exp_q[0].wmask);
                        end
                    end
                    strobe_cyc[g] <= cyc;
                end
                if (ack_0[g] || ack_1[g]) begin
                    check("ack_pulse", prev_ack[g], 1'b0);
                    check("ack_one_port", ack_0[g] & ack_1[g], 1'b0);
                    check("ack_owner", owner(), g);
                    if (owner() == g) begin
                        mon_e = exp_q.pop_front();
                        check("ack_port", ack_1[g], mon_e.port);
                        check("grant_id", grant_id[g], mon_e.port);
                        check("rdata", rdata[g], mon_e.rdata);
                        check("latency", cyc - strobe_cyc[g], lat_of(g) + 1);
                        check("busy_in_release", busy[g], 1'b1);
                        check("addr_held", mem_address[g], mon_e.addr);
                    end
                end
                if (prev_ack[g]) check("busy_drop", busy[g], 1'b0);
            end
            prev_be[g]  <= mem_bus_enable[g];
            prev_ack[g] <= ack_0[g] | ack_1[g];
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0;
        for (int g = 0; g < N; g++) begin
            req_0[g] = 1'b0; req_1[g] = 1'b0;
            set_port(g, PORT_CPU, 16'h0, 1'b0, 32'h0, 4'hF);
            set_port(g, PORT_DMA, 16'h0, 1'b0, 32'h0, 4'hF);
            last_rd[g] = 32'h0;
        end
        repeat (3) @(negedge clk);
        for (int g = 0; g < N; g++) begin
            check("rst_busy", busy[g], 1'b0);
            check("rst_ack", {ack_0[g], ack_1[g]}, 2'b00);
            check("rst_strobes", {mem_bus_enable[g], mem_write_enable[g]}, 2'b00);
            check("rst_rdata", rdata[g], 32'h0);
            check("rst_addr", mem_address[g], 16'h0);
            check("rst_grant_id", grant_id[g], 1'b0);
        end
        reset_n = 1'b1;

        // Round-robin: both ports held, eight alternating grants starting with port 0.
        set_port(0, PORT_CPU, 16'h0100, 1'b0, 32'h0, 4'hF);
        set_port(0, PORT_DMA, 16'h0204, 1'b0, 32'h0, 4'hF);
        for (int k = 0; k < 8; k++) begin
            if (k % 2 == 0) push(0, PORT_CPU, 16'h0100, 1'b0, 32'h0, 4'hF, init_word(16'h0100));
            else            push(0, PORT_DMA, 16'h0204, 1'b0, 32'h0, 4'hF, init_word(16'h0204));
        end
        hold_run(0, 1'b1, 1'b1, 8, 0, 1'b0);

        // Single read, requester inputs corrupted mid-transaction.
        set_port(0, PORT_CPU, 16'h4000, 1'b0, 32'h0, 4'hF);
        push(0, PORT_CPU, 16'h4000, 1'b0, 32'h0, 4'hF, 32'hDEAD_BEEF);
        hold_run(0, 1'b1, 1'b0, 1, 0, 1'b1);

        // Byte write to lane 2, then read the word back.
        set_port(0, PORT_DMA, 16'h8002, 1'b1, 32'h5555_5555, 4'b1011);
        push(0, PORT_DMA, 16'h8002, 1'b1, 32'h5555_5555, 4'b1011, 32'h0);
        hold_run(0, 1'b0, 1'b1, 1, 0, 1'b0);
        set_port(0, PORT_CPU, 16'h8000, 1'b0, 32'h0, 4'hF);
        push(0, PORT_CPU, 16'h8000, 1'b0, 32'h0, 4'hF, 32'h0055_0000);
        hold_run(0, 1'b1, 1'b0, 1, 0, 1'b0);

        // Requester error: req_0 held through RELEASE gives a clean second grant.
        set_port(0, PORT_CPU, 16'h4000, 1'b0, 32'h0, 4'hF);
        push(0, PORT_CPU, 16'h4000, 1'b0, 32'h0, 4'hF, 32'hDEAD_BEEF);
        push(0, PORT_CPU, 16'h4000, 1'b0, 32'h0, 4'hF, 32'hDEAD_BEEF);
        hold_run(0, 1'b1, 1'b0, 2, 0, 1'b0);

        // Fixed priority: port 1 only served once req_0 drops.
        set_port(1, PORT_CPU, 16'h0300, 1'b0, 32'h0, 4'hF);
        set_port(1, PORT_DMA, 16'h0404, 1'b0, 32'h0, 4'hF);
        for (int k = 0; k < 4; k++) push(1, PORT_CPU, 16'h0300, 1'b0, 32'h0, 4'hF, init_word(16'h0300));
        push(1, PORT_DMA, 16'h0404, 1'b0, 32'h0, 4'hF, init_word(16'h0404));
        hold_run(1, 1'b1, 1'b1, 5, 4, 1'b0);

        // LATENCY=3 read.
        set_port(2, PORT_CPU, 16'h4000, 1'b0, 32'h0, 4'hF);
        push(2, PORT_CPU, 16'h4000, 1'b0, 32'h0, 4'hF, 32'hDEAD_BEEF);
        hold_run(2, 1'b1, 1'b0, 1, 0, 1'b1);

        // Reset while the strobe is high aborts without ack.
        set_port(2, PORT_DMA, 16'h0500, 1'b0, 32'h0, 4'hF);
        push(2, PORT_DMA, 16'h0500, 1'b0, 32'h0, 4'hF, init_word(16'h0500));
        @(negedge clk);
        req_1[2] = 1'b1;
        for (int w = 0; w < 20 && !mem_bus_enable[2]; w++) @(negedge clk);
        check("pre_reset_enable", mem_bus_enable[2], 1'b1);
        reset_n = 1'b0;
        #1;
        check("abort_enable", mem_bus_enable[2], 1'b0);
        check("abort_busy", busy[2], 1'b0);
        check("abort_ack", {ack_0[2], ack_1[2]}, 2'b00);
        check("abort_addr", mem_address[2], 16'h0);
        exp_q.delete();
        req_1[2] = 1'b0;
        for (int g = 0; g < N; g++) last_rd[g] = 32'h0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (6) @(negedge clk);

        // First tie after reset goes to port 0.
        set_port(2, PORT_CPU, 16'h0600, 1'b0, 32'h0, 4'hF);
        set_port(2, PORT_DMA, 16'h0704, 1'b0, 32'h0, 4'hF);
        push(2, PORT_CPU, 16'h0600, 1'b0, 32'h0, 4'hF, init_word(16'h0600));
        push(2, PORT_DMA, 16'h0704, 1'b0, 32'h0, 4'hF, init_word(16'h0704));
        hold_run(2, 1'b1, 1'b1, 2, 0, 1'b0);

        repeat (4) @(negedge clk);
        check("queue_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
